// File: rtl/video_cfg_sync.sv
`default_nettype none
// ============================================================================
// Module   : video_cfg_sync
// Purpose  : Queues configuration writes for a set of downstream video cores
//            and only applies them at a frame boundary. When a frame-start
//            beat arrives with writes pending, the stream is held while the
//            queued writes are replayed, one per cycle, to the cores.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            avs_*                - config write slave {core_sel, reg_addr}
//            core_*               - one-hot write strobe, address, data out
//            src_* / snk_*        - zero-latency pixel stream pass-through
// Options  : VIDEO_CFG_SYNC_TIMEOUT_EN - when defined, writes pending for
//            TIMEOUT_CYC stream cycles are drained without waiting for a
//            frame start.
// Revision : 1.0 - initial release
// ============================================================================

package video_cfg_sync_pkg;
    typedef struct packed {
        logic [10:0] vc;
        logic [10:0] hc;
    } vga_fc_t;
endpackage

module video_cfg_sync
    import video_cfg_sync_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int CORE_AW     = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int RGB_SIZE    = 12,
    parameter int TIMEOUT_CYC = 2000000,
    localparam int c_csw      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       avs_write,
    input  logic [c_csw+CORE_AW-1:0]   avs_address,
    input  logic [31:0]                avs_writedata,
    output logic                       avs_waitrequest,
    output logic [NUM_CORES-1:0]       core_write,
    output logic [CORE_AW-1:0]         core_address,
    output logic [31:0]                core_writedata,
    input  logic                       src_vld,
    output logic                       src_rdy,
    input  vga_fc_t                    src_fc,
    input  logic [RGB_SIZE-1:0]        src_rgb,
    input  logic                       snk_rdy,
    output logic                       snk_vld,
    output vga_fc_t                    snk_fc,
    output logic [RGB_SIZE-1:0]        snk_rgb
);

    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_ew = c_csw + CORE_AW + 32;

    localparam logic [c_csw:0]  c_num_cores = (c_csw + 1)'(NUM_CORES);
    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

    localparam logic [0:0] c_st_pass  = 1'b0;
    localparam logic [0:0] c_st_drain = 1'b1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [c_ew-1:0]    r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw:0]      r_count;
    logic [c_aw:0]      r_drain_cnt;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_armed;

    logic [c_csw-1:0]   w_avs_sel;
    logic [CORE_AW-1:0] w_avs_reg;
    logic [c_ew-1:0]    w_head;
    logic [c_csw-1:0]   w_head_sel;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_fs;
    logic               w_in_pass;
    logic               w_tmo_hit;
    logic               w_stall_req;

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    assign w_avs_sel       = avs_address[c_csw+CORE_AW-1 -: c_csw];
    assign w_avs_reg       = avs_address[CORE_AW-1:0];
    assign w_full          = (r_count == c_depth);
    assign w_empty         = (r_count == '0);
    assign avs_waitrequest = w_full;

    // Writes to cores that do not exist are acknowledged but never queued.
    assign w_push = avs_write & ~w_full & ({1'b0, w_avs_sel} < c_num_cores);

    // drain_cnt never reaches zero inside DRAIN, so every DRAIN cycle pops.
    assign w_pop = (r_state == c_st_drain);

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sel = w_head[c_ew-1 -: c_csw];

    assign core_address   = w_head[32 +: CORE_AW];
    assign core_writedata = w_head[31:0];

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core_wr
        assign core_write[gi] = w_pop & (w_head_sel == c_csw'(gi));
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_avs_sel, w_avs_reg, avs_writedata};
        end
    end

    // ------------------------------------------------------------------
    // Stream gating
    // ------------------------------------------------------------------
    assign w_fs        = src_vld & (src_fc.hc == '0) & (src_fc.vc == '0);
    assign w_in_pass   = (r_state == c_st_pass);
    assign w_stall_req = w_in_pass & ((w_fs & r_armed & ~w_empty) | w_tmo_hit);

    assign snk_vld = src_vld & w_in_pass & ~w_stall_req;
    assign src_rdy = snk_rdy & w_in_pass & ~w_stall_req;
    assign snk_fc  = src_fc;
    assign snk_rgb = src_rgb;

    // ------------------------------------------------------------------
    // Optional forced drain for queues left pending too long
    // ------------------------------------------------------------------
`ifdef VIDEO_CFG_SYNC_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYC);
    localparam logic [c_tmo_w-1:0] c_tmo_one = c_tmo_w'(1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_stall_req) begin
            r_tmo_cnt <= '0;
        end else if (w_in_pass & ~w_empty) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
        end
    end

    assign w_tmo_hit = w_in_pass & ~w_empty & (r_tmo_cnt == c_tmo_max);
`else
    // No counter in this build; the expression only keeps TIMEOUT_CYC referenced.
    assign w_tmo_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_pass;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_pass: begin
                if (w_stall_req) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (r_drain_cnt == c_cnt_one) begin
                    w_state_nxt = c_st_pass;
                end
            end
            default: w_state_nxt = c_st_pass;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, drain length and re-arm flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drain_cnt <= '0;
            r_armed     <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            // Only entries present at the stall are drained; anything pushed
            // from that cycle on waits for the next frame.
            if (w_stall_req) begin
                r_drain_cnt <= r_count;
            end else if (w_pop) begin
                r_drain_cnt <= r_drain_cnt - c_cnt_one;
            end

            // Disarming lets the held frame-start beat through after DRAIN;
            // the next ordinary beat re-arms for the following frame.
            if (w_stall_req) begin
                r_armed <= 1'b0;
            end else if (src_vld & src_rdy & ~w_fs) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_cfg_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_cfg_sync
// Purpose  : Self-checking bench for video_cfg_sync. Issued config writes are
//            queued as expected core writes; a monitor pops and compares each
//            core_write pulse. A second instance with NUM_CORES=3 covers the
//            out-of-range core select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_cfg_sync;
    import video_cfg_sync_pkg::*;

    localparam int c_tmo = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          avs_write;
    logic          avs_write3;
    logic [3:0]    avs_address;
    logic [31:0]   avs_writedata;
    logic          src_vld;
    vga_fc_t       src_fc;
    logic [11:0]   src_rgb;
    logic          snk_rdy;

    logic          avs_waitrequest;
    logic [3:0]    core_write;
    logic [1:0]    core_address;
    logic [31:0]   core_writedata;
    logic          src_rdy;
    logic          snk_vld;
    vga_fc_t       snk_fc;
    logic [11:0]   snk_rgb;

    logic          avs_waitrequest3;
    logic [2:0]    core_write3;
    logic [1:0]    core_address3;
    logic [31:0]   core_writedata3;
    logic          src_rdy3;
    logic          snk_vld3;
    vga_fc_t       snk_fc3;
    logic [11:0]   snk_rgb3;

    always #5 clk = ~clk;

    video_cfg_sync #(
        .NUM_CORES(4), .CORE_AW(2), .FIFO_DEPTH(8), .RGB_SIZE(12), .TIMEOUT_CYC(c_tmo)
    ) dut (
        .clk(clk), .rst(rst),
        .avs_write(avs_write), .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_waitrequest(avs_waitrequest),
        .core_write(core_write), .core_address(core_address), .core_writedata(core_writedata),
        .src_vld(src_vld), .src_rdy(src_rdy), .src_fc(src_fc), .src_rgb(src_rgb),
        .snk_rdy(snk_rdy), .snk_vld(snk_vld), .snk_fc(snk_fc), .snk_rgb(snk_rgb)
    );

    video_cfg_sync #(
        .NUM_CORES(3), .CORE_AW(2), .FIFO_DEPTH(8), .RGB_SIZE(12), .TIMEOUT_CYC(c_tmo)
    ) dut3 (
        .clk(clk), .rst(rst),
        .avs_write(avs_write3), .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_waitrequest(avs_waitrequest3),
        .core_write(core_write3), .core_address(core_address3), .core_writedata(core_writedata3),
        .src_vld(src_vld), .src_rdy(src_rdy3), .src_fc(src_fc), .src_rgb(src_rgb),
        .snk_rdy(snk_rdy), .snk_vld(snk_vld3), .snk_fc(snk_fc3), .snk_rgb(snk_rgb3)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;
    logic drain_ok = 1'b0;
    logic done;
    int   cyc;
    int   p0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every core_write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (core_write !== 4'b0000) begin
            n_pulses++;
            if (!drain_ok) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_core_write: got %b expected 0000", core_write);
            end else if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got core_write %b expected none", core_write);
            end else begin
                m_e = sb.pop_front();
                chk("core_write", 64'(core_write), 64'(4'b0001 << m_e.sel));
                chk("core_address", 64'(core_address), 64'(m_e.addr));
                chk("core_writedata", 64'(core_writedata), 64'(m_e.data));
            end
        end
        if (core_write3 !== 3'b000) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut3_core_write: got %b expected 000", core_write3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [1:0] sel, input logic [1:0] addr, input logic [31:0] data,
                          input logic exp_wait, input logic exp_push);
        avs_address   = {sel, addr};
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        chk("avs_waitrequest", 64'(avs_waitrequest), 64'(exp_wait));
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        if (exp_push) sb.push_back(exp_t'{sel, addr, data});
    endtask

    task automatic mid_beat(input logic [11:0] rgb);
        src_vld   = 1'b1;
        src_fc.hc = 11'd7;
        src_fc.vc = 11'd3;
        src_rgb   = rgb;
        @(negedge clk);
        chk("snk_vld_pass", 64'(snk_vld), 64'(1));
        chk("snk_rgb_pass", 64'(snk_rgb), 64'(rgb));
        chk("snk_fc_pass", 64'(snk_fc), 64'({11'd3, 11'd7}));
        chk("src_rdy_pass", 64'(src_rdy), 64'(snk_rdy));
        @(posedge clk);
        #1;
    endtask

    // Present a frame-start beat, count stalled cycles and drained writes.
    task automatic run_fs(input int pops, input logic rdy, input logic [11:0] rgb);
        int   stall = 0;
        int   pst;
        logic rel = 1'b0;
        pst      = n_pulses;
        drain_ok = 1'b1;
        snk_rdy  = rdy;
        src_vld  = 1'b1;
        src_fc   = '0;
        src_rgb  = rgb;
        for (int i = 0; i < 64 && !rel; i++) begin
            @(negedge clk);
            if (snk_vld) rel = 1'b1;
            else begin
                stall++;
                @(posedge clk);
                #1;
            end
        end
        chk("fs_released", 64'(rel), 64'(1));
        chk("stall_cycles", 64'(stall), 64'((pops == 0) ? 0 : pops + 1));
        chk("fs_rgb", 64'(snk_rgb), 64'(rgb));
        chk("drain_pops", 64'(n_pulses - pst), 64'(pops));
        snk_rdy = 1'b1;
        tick();
        src_fc.hc = 11'd1;
        src_fc.vc = 11'd0;
        tick();
        src_vld  = 1'b0;
        drain_ok = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; avs_write = 1'b0; avs_write3 = 1'b0; avs_address = '0; avs_writedata = '0;
        src_vld = 1'b0; src_fc = '0; src_rgb = '0; snk_rdy = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_waitrequest", 64'(avs_waitrequest), 64'(0));
        chk("rst_core_write", 64'(core_write), 64'(0));
        chk("rst_src_rdy", 64'(src_rdy), 64'(1));
        chk("rst_snk_vld", 64'(snk_vld), 64'(0));
        tick();

        // Out-of-range core select on the 3-core instance is dropped
        avs_address = {2'd3, 2'd1}; avs_writedata = 32'hDEAD_0003; avs_write3 = 1'b1;
        @(negedge clk);
        chk("dut3_waitrequest", 64'(avs_waitrequest3), 64'(0));
        tick();
        avs_write3 = 1'b0;
        src_vld = 1'b1; src_fc = '0; src_rgb = 12'h3C3;
        @(negedge clk);
        chk("dut3_fs_no_stall", 64'(snk_vld3), 64'(1));
        chk("dut3_src_rdy", 64'(src_rdy3), 64'(1));
        tick();
        mid_beat(12'h010);

        // Three writes to core 1 mid-frame, applied at the next frame start
        mid_beat(12'h123);
        for (int i = 0; i < 3; i++) avs_wr(2'd1, 2'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        mid_beat(12'h456);
        snk_rdy = 1'b0;
        mid_beat(12'h789);
        snk_rdy = 1'b1;
        mid_beat(12'h9AB);
        run_fs(3, 1'b1, 12'hABC);

        // Nine back-to-back writes: the ninth sees a full queue
        for (int i = 0; i < 8; i++) avs_wr(2'(i % 4), 2'(3 - (i % 4)), 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
        avs_wr(2'd2, 2'd2, 32'hB000_0008, 1'b1, 1'b0);
        run_fs(8, 1'b1, 12'h0F0);
        avs_wr(2'd2, 2'd2, 32'hB000_0008, 1'b0, 1'b1);
        run_fs(1, 1'b1, 12'h0F1);

        // Writes arriving during a two-entry drain, with the sink not ready
        avs_wr(2'd0, 2'd0, 32'hC000_0000, 1'b0, 1'b1);
        avs_wr(2'd2, 2'd1, 32'hC000_0001, 1'b0, 1'b1);
        fork
            run_fs(2, 1'b0, 12'h444);
            begin
                avs_wr(2'd3, 2'd2, 32'hC000_0002, 1'b0, 1'b1);
                avs_wr(2'd1, 2'd3, 32'hC000_0003, 1'b0, 1'b1);
            end
        join
        mid_beat(12'h555);
        run_fs(2, 1'b1, 12'h666);

        // Reset in the middle of a five-entry drain
        for (int i = 0; i < 5; i++) avs_wr(2'(i % 4), 2'(i % 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b1);
        p0 = n_pulses; drain_ok = 1'b1;
        src_vld = 1'b1; src_fc = '0; src_rgb = 12'h777;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            tick();
            if (n_pulses - p0 >= 2) done = 1'b1;
        end
        chk("rst_drain_started", 64'(done), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0; drain_ok = 1'b0;
        sb.delete();
        p0 = n_pulses;
        @(negedge clk);
        chk("rst_mid_core_write", 64'(core_write), 64'(0));
        chk("rst_mid_waitrequest", 64'(avs_waitrequest), 64'(0));
        chk("rst_mid_stream_pass", 64'(snk_vld), 64'(1));
        tick();
        src_vld = 1'b0;
        repeat (8) tick();
        chk("rst_mid_no_pulses", 64'(n_pulses - p0), 64'(0));
        mid_beat(12'h888);
        run_fs(0, 1'b1, 12'h999);

`ifdef VIDEO_CFG_SYNC_TIMEOUT_EN
        // Idle stream with a pending write: drained by the timeout
        drain_ok = 1'b1;
        src_vld  = 1'b0;
        avs_wr(2'd2, 2'd3, 32'hE000_0077, 1'b0, 1'b1);
        done = 1'b0; cyc = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (core_write !== 4'b0000) begin
                done = 1'b1;
                cyc  = i;
            end else begin
                tick();
            end
        end
        chk("tmo_fired", 64'(done), 64'(1));
        chk("tmo_cycle_window", 64'((cyc >= c_tmo - 1) && (cyc <= c_tmo + 2)), 64'(1));
        tick();
        drain_ok = 1'b0;
`endif

        repeat (2) tick();
        chk("sb_empty_end", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_cfg_sync.md
VIDEO_CFG_SYNC -- requirements
Module: video_cfg_sync

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be honoured as listed:
- NUM_CORES, 4, number of downstream video cores.
- CORE_AW, 2, per-core register address width.
- FIFO_DEPTH, 8, write-queue depth (power of 2).
- RGB_SIZE, 12, pixel width.
- TIMEOUT_CYC, 2000000, forced-drain timeout.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, reset.
- avs_write, in, 1, config write strobe.
- avs_address, in, CSW+CORE_AW, {core_sel, reg_addr}; CSW=$clog2(NUM_CORES).
- avs_writedata, in, 32, write data.
- avs_waitrequest, out, 1, queue full.
- core_write, out, NUM_CORES, one-hot write strobe to cores.
- core_address, out, CORE_AW, core register address.
- core_writedata, out, 32, core write data.
- src_vld, in, 1, upstream valid.
- src_rdy, out, 1, upstream ready.
- src_fc, in, vga_fc_t, frame counters.
- src_rgb, in, RGB_SIZE, upstream pixel.
- snk_rdy, in, 1, downstream ready.
- snk_vld, out, 1, downstream valid.
- snk_fc, out, vga_fc_t, downstream frame counters.
- snk_rgb, out, RGB_SIZE, downstream pixel.
REQ-003 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 Accepted write (avs_write & ~avs_waitrequest) with core_sel<NUM_CORES SHALL push {core_sel, reg_addr, data} into the FIFO; core_sel>=NUM_CORES SHALL be dropped silently.
REQ-005 avs_waitrequest SHALL equal FIFO full, combinationally; writes while full are ignored, not lost-and-acked.
REQ-006 Frame-start beat (fs) = src_vld & src_fc.hc==0 & src_fc.vc==0.
REQ-007 FSM states PASS and DRAIN; stream SHALL pass through combinationally (0 latency) in PASS: snk_fc=src_fc, snk_rgb=src_rgb.
REQ-008 stall_req = fs & armed & FIFO non-empty; snk_vld = src_vld & PASS & ~stall_req; src_rdy = snk_rdy & PASS & ~stall_req.
REQ-009 PASS->DRAIN when stall_req; drain_cnt SHALL capture the FIFO occupancy at that cycle.
REQ-010 In DRAIN, one entry SHALL pop per cycle, driving core_write[sel]=1 (single cycle), core_address, core_writedata, in FIFO order; exactly drain_cnt entries pop, then DRAIN->PASS.
REQ-011 Writes pushed during DRAIN SHALL remain queued for the next frame; simultaneous push and pop SHALL be supported.
REQ-012 armed SHALL clear on entering DRAIN and set on any accepted non-fs beat, so the held frame-start beat passes after DRAIN; stall SHALL be drain_cnt+1 cycles.
REQ-013 core_write SHALL be all-zero outside DRAIN pops; core_address/core_writedata are don't-care when core_write==0.
REQ-014 snk_rdy deassertion SHALL NOT affect DRAIN progress.

Reset
REQ-015 On rst: FIFO empty, state PASS, armed=1, drain_cnt=0, timeout counter=0, core_write=0, avs_waitrequest=0.
REQ-016 rst mid-DRAIN SHALL discard all queued entries with no further core_write pulses.

Configuration
REQ-017 With macro VIDEO_CFG_SYNC_TIMEOUT_EN defined: a counter SHALL increment each PASS cycle while the FIFO is non-empty and no DRAIN occurs; at TIMEOUT_CYC it SHALL force PASS->DRAIN regardless of fs (stream gated identically) and clear on DRAIN entry.
REQ-018 Without VIDEO_CFG_SYNC_TIMEOUT_EN the counter SHALL not exist; DRAIN is entered only via REQ-009.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- 3 writes to core 1 mid-frame -> no core_write until fs beat; then src_rdy low 4 cycles, core_write=4'b0010 for 3 consecutive cycles in order, fs beat then passes.
- 9 writes back-to-back with FIFO_DEPTH=8 -> avs_waitrequest high on 9th; after drain, 9th accepted and applied next frame.
- write to core_sel=3 with NUM_CORES=3 -> dropped, FIFO stays empty, no stall at fs.
- writes arriving during DRAIN of 2 entries -> only 2 pops this frame, new ones at next fs.
- rst asserted during DRAIN with 5 entries queued -> core_write=0 from next cycle, FIFO empty, stream passes.
- TIMEOUT_EN, TIMEOUT_CYC=100, src_vld held low -> forced DRAIN at cycle 100.
